uart_mem_access_ctrl: RTL and testbench

- Command sequencer between the UART byte receiver/transmitter and the instruction/data memories.
- Parses host frames into run/halt control, memory writes and memory reads.
- Pauses the CPU (enable low) around each access and drives the memory debug port (write_mem_req, target_mem_type, target_addr, rw_flag, data).
- Serializes the 42-bit read response back to the host as bytes.

---
 rtl/uart_ctrl_pkg.sv | 36 +++
 rtl/uart_rsp_serializer.sv | 54 +++++
 rtl/uart_mem_access_ctrl.sv | 179 +++++++++++++++++
 tb/tb_uart_mem_access_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared encodings for the UART memory-access controller: frame opcodes,
// FSM states, default reply bytes and memory response field widths.
package uart_ctrl_pkg;

  localparam int unsigned RSP_W  = 42;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SER_W  = 48;

  localparam logic [7:0] DEF_ACK_BYTE = 8'hA5;
  localparam logic [7:0] DEF_ERR_BYTE = 8'hEE;

  typedef enum logic [1:0] {
    OP_HALT  = 2'b00,
    OP_RUN   = 2'b01,
    OP_WRITE = 2'b10,
    OP_READ  = 2'b11
  } op_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_PAUSE,
    ST_ISSUE,
    ST_WAIT_RSP,
    ST_TX_RSP,
    ST_TX_ACK,
    ST_TX_ERR
  } state_e;

  function automatic logic is_tx_state(input state_e s);
    return (s == ST_TX_RSP) || (s == ST_TX_ACK) || (s == ST_TX_ERR);
  endfunction

endpackage

// File: rtl/uart_rsp_serializer.sv
// Byte serializer: loads up to 48 bits plus a byte count and emits them MSB
// first over a valid/ready handshake; done pulses as the last byte is taken.
module uart_rsp_serializer
  import uart_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [SER_W-1:0] load_word,
  input  logic [2:0]       load_cnt,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             done
);

  logic [SER_W-1:0] word_q, word_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             accept;

  assign accept   = valid_q & tx_ready;
  assign done     = accept & (cnt_q == 3'd1);
  assign tx_data  = word_q[SER_W-1 -: 8];
  assign tx_valid = valid_q;

  always_comb begin
    word_d  = word_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (load) begin
      word_d  = load_word;
      cnt_d   = load_cnt;
      valid_d = (load_cnt != 3'd0);
    end else if (accept) begin
      word_d = {word_q[SER_W-9:0], 8'h00};
      cnt_d  = cnt_q - 3'd1;
      if (cnt_q == 3'd1) valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/uart_mem_access_ctrl.sv
// Host command sequencer: parses UART frames into run/halt, memory write and
// memory read, pauses the CPU around each access and returns the reply bytes.
module uart_mem_access_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned RX_TIMEOUT  = 65535,
  parameter int unsigned RSP_TIMEOUT = 8,
  parameter logic [7:0]  ACK_BYTE    = DEF_ACK_BYTE,
  parameter logic [7:0]  ERR_BYTE    = DEF_ERR_BYTE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              enable,
  output logic              write_mem_req,
  output logic              target_mem_type,
  output logic [ADDR_W-1:0] target_addr,
  output logic              rw_flag,
  output logic [DATA_W-1:0] uart_rx_data_out,
  input  logic              instr_mem_tx_data_ready,
  input  logic [RSP_W-1:0]  instr_mem_tx_data,
  input  logic              data_mem_tx_data_ready,
  input  logic [RSP_W-1:0]  data_mem_tx_data,
  output logic              busy
);

  state_e            state_q, state_d;
  logic              run_flag_q, run_flag_d;
  logic              enable_q;
  logic              wr_req_q;
  logic              mem_type_q, mem_type_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       tmr_q, tmr_d;

  op_e               hdr_op;
  logic              sel_ready;
  logic [RSP_W-1:0]  sel_word;
  logic              ser_load;
  logic [SER_W-1:0]  ser_word;
  logic [2:0]        ser_cnt;
  logic              ser_done;

  assign hdr_op    = op_e'(rx_data[7:6]);
  assign sel_ready = mem_type_q ? instr_mem_tx_data_ready : data_mem_tx_data_ready;
  assign sel_word  = mem_type_q ? instr_mem_tx_data : data_mem_tx_data;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      run_flag_q <= 1'b0;
      enable_q   <= 1'b0;
      wr_req_q   <= 1'b0;
      mem_type_q <= 1'b0;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      wdata_q    <= '0;
      byte_cnt_q <= '0;
      tmr_q      <= '0;
    end else begin
      state_q    <= state_d;
      run_flag_q <= run_flag_d;
      // Built from next-state values so enable tracks the state it describes.
      enable_q   <= run_flag_d & (state_d == ST_IDLE);
      wr_req_q   <= (state_d == ST_ISSUE);
      mem_type_q <= mem_type_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      wdata_q    <= wdata_d;
      byte_cnt_q <= byte_cnt_d;
      tmr_q      <= tmr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    run_flag_d = run_flag_q;
    mem_type_d = mem_type_q;
    addr_d     = addr_q;
    rw_d       = rw_q;
    wdata_d    = wdata_q;
    byte_cnt_d = byte_cnt_q;
    tmr_d      = tmr_q + 32'd1;
    unique case (state_q)
      ST_IDLE: begin
        tmr_d = '0;
        if (rx_valid) begin
          if (rx_data[4:1] != 4'd0) begin
            state_d = ST_TX_ERR;
          end else if (hdr_op == OP_HALT || hdr_op == OP_RUN) begin
            run_flag_d = rx_data[6];
            state_d    = ST_TX_ACK;
          end else begin
            mem_type_d = rx_data[5];
            addr_d[8]  = rx_data[0];
            rw_d       = (hdr_op == OP_WRITE);
            state_d    = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        if (rx_valid) begin
          addr_d[7:0] = rx_data;
          tmr_d       = '0;
          byte_cnt_d  = '0;
          state_d     = rw_q ? ST_DATA : ST_PAUSE;
        end else if (tmr_q == RX_TIMEOUT - 1) begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (rx_valid) begin
          wdata_d    = {wdata_q[DATA_W-9:0], rx_data};
          tmr_d      = '0;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = ST_PAUSE;
        end else if (tmr_q == RX_TIMEOUT - 1) begin
          state_d = ST_IDLE;
        end
      end
      ST_PAUSE: state_d = ST_ISSUE;
      ST_ISSUE: begin
        tmr_d   = '0;
        state_d = rw_q ? ST_TX_ACK : ST_WAIT_RSP;
      end
      ST_WAIT_RSP: begin
        if (sel_ready)                      state_d = ST_TX_RSP;
        else if (tmr_q == RSP_TIMEOUT - 1)  state_d = ST_TX_ERR;
      end
      ST_TX_RSP, ST_TX_ACK, ST_TX_ERR: begin
        if (ser_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: the serializer is loaded on entry to any TX state; the
  // response word is taken straight from the selected memory that same cycle.
  always_comb begin
    ser_load = is_tx_state(state_d) && !is_tx_state(state_q);
    ser_word = {ACK_BYTE, {(SER_W-8){1'b0}}};
    ser_cnt  = 3'd1;
    if (state_d == ST_TX_RSP) begin
      ser_word = {{(SER_W-RSP_W){1'b0}}, sel_word};
      ser_cnt  = 3'd6;
    end else if (state_d == ST_TX_ERR) begin
      ser_word = {ERR_BYTE, {(SER_W-8){1'b0}}};
    end
  end

  uart_rsp_serializer u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ser_load),
    .load_word(ser_word),
    .load_cnt (ser_cnt),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .done     (ser_done)
  );

  assign enable           = enable_q;
  assign write_mem_req    = wr_req_q;
  assign target_mem_type  = mem_type_q;
  assign target_addr      = addr_q;
  assign rw_flag          = rw_q;
  assign uart_rx_data_out = wdata_q;
  assign busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_mem_access_ctrl.sv
// Directed bench for uart_mem_access_ctrl with a small memory responder model.
module tb_uart_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        enable, write_mem_req, target_mem_type, rw_flag, busy;
  logic [8:0]  target_addr;
  logic [31:0] uart_rx_data_out;
  logic        instr_rdy, data_rdy;
  logic [41:0] instr_word, data_word;

  logic        rsp_en = 1'b0, instr_force = 1'b0, data_force = 1'b0;
  logic        instr_pulse = 1'b0, pend = 1'b0;

  int          n_assert = 0, n_fail = 0;
  int          strobe_cnt = 0, tx_acc_cnt = 0;
  logic        s_type, s_rw, s_en, post_chk = 1'b0;
  logic        p_type, p_rw;
  logic [8:0]  s_addr, p_addr;
  logic [31:0] s_data;
  logic [7:0]  txq[$];

  always #5 clk = ~clk;

  assign instr_word = {1'b1, 9'h003, 32'hDEADBEEF};
  assign data_word  = {1'b1, 9'h1FF, 32'h00000000};
  assign instr_rdy  = instr_pulse | instr_force;
  assign data_rdy   = data_force;

  uart_mem_access_ctrl #(.RX_TIMEOUT(20), .RSP_TIMEOUT(8)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .rx_data                (rx_data),
    .rx_valid               (rx_valid),
    .tx_data                (tx_data),
    .tx_valid               (tx_valid),
    .tx_ready               (tx_ready),
    .enable                 (enable),
    .write_mem_req          (write_mem_req),
    .target_mem_type        (target_mem_type),
    .target_addr            (target_addr),
    .rw_flag                (rw_flag),
    .uart_rx_data_out       (uart_rx_data_out),
    .instr_mem_tx_data_ready(instr_rdy),
    .instr_mem_tx_data      (instr_word),
    .data_mem_tx_data_ready (data_rdy),
    .data_mem_tx_data       (data_word),
    .busy                   (busy)
  );

  // Monitor strobes/handshakes and answer instruction reads one cycle after the strobe
  always @(negedge clk) begin
    instr_pulse = pend;
    pend = write_mem_req && !rw_flag && target_mem_type && rsp_en;
    if (post_chk) begin
      p_type = target_mem_type; p_rw = rw_flag; p_addr = target_addr; post_chk = 1'b0;
    end
    if (write_mem_req) begin
      strobe_cnt++;
      s_type = target_mem_type; s_rw = rw_flag; s_addr = target_addr;
      s_data = uart_rx_data_out; s_en = enable; post_chk = 1'b1;
    end
    if (tx_valid && tx_ready) tx_acc_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  // Accept n bytes into txq; with toggle, tx_ready alternates and held bytes are checked
  task automatic collect(input int n, input bit toggle);
    int budget = 200;
    bit prev_stall = 1'b0;
    logic [7:0] held = '0;
    while (txq.size() < n && budget > 0) begin
      tx_ready = toggle ? ~tx_ready : 1'b1;
      if (prev_stall) chk("stall_hold", {tx_valid, tx_data}, {1'b1, held});
      prev_stall = tx_valid && !tx_ready;
      held = tx_data;
      if (tx_valid && tx_ready) txq.push_back(tx_data);
      tick();
      budget--;
    end
  endtask

  function automatic logic [7:0] qb(input int i);
    return (i < txq.size()) ? txq[i] : 8'hxx;
  endfunction

  initial begin
    int s0, a0, n;
    logic [7:0] exp_rd [6];
    exp_rd = '{8'h02, 8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF};

    repeat (3) tick();
    chk("rst_enable", enable, 0);
    chk("rst_txv", tx_valid, 0);
    chk("rst_txd", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wreq", write_mem_req, 0);
    chk("rst_addr", target_addr, 0);
    chk("rst_wdata", uart_rx_data_out, 0);
    rst_n = 1'b1;
    tick();

    // run
    tx_ready = 1'b1;
    send_byte(8'h40);
    chk("run_txv", tx_valid, 1);
    chk("run_txd", tx_data, 8'hA5);
    chk("run_en_lo", enable, 0);
    chk("run_busy", busy, 1);
    tick();
    chk("run_en_hi", enable, 1);
    chk("run_idle", busy, 0);
    chk("run_txv_off", tx_valid, 0);

    // write to instruction memory
    s0 = strobe_cnt;
    send_byte(8'hA0);
    chk("wr_en_lo", enable, 0);
    send_byte(8'h05); send_byte(8'h12); send_byte(8'h34);
    send_byte(8'h56); send_byte(8'h78);
    txq.delete();
    collect(1, 1'b0);
    chk("wr_ack_n", txq.size(), 1);
    chk("wr_ack", qb(0), 8'hA5);
    chk("wr_strobes", strobe_cnt - s0, 1);
    chk("wr_type", s_type, 1);
    chk("wr_rw", s_rw, 1);
    chk("wr_addr", s_addr, 9'h005);
    chk("wr_data", s_data, 32'h12345678);
    chk("wr_en_at_strobe", s_en, 0);
    chk("wr_post_stable", {p_type, p_rw, p_addr}, {1'b1, 1'b1, 9'h005});
    chk("wr_en_back", enable, 1);

    // read from instruction memory, data memory ready held high as a decoy
    rsp_en = 1'b1; data_force = 1'b1; s0 = strobe_cnt;
    send_byte(8'hE1); send_byte(8'h03);
    txq.delete();
    collect(6, 1'b1);
    chk("rd_nbytes", txq.size(), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("rd_byte%0d", i), qb(i), exp_rd[i]);
    chk("rd_strobes", strobe_cnt - s0, 1);
    chk("rd_tgt", {s_type, s_rw, s_addr}, {1'b1, 1'b0, 9'h103});
    rsp_en = 1'b0; data_force = 1'b0;

    // data memory read with no response, instruction ready held high as a decoy
    instr_force = 1'b1; tx_ready = 1'b0; s0 = strobe_cnt;
    send_byte(8'hC0); send_byte(8'h10);
    n = 0;
    while (!tx_valid && n < 50) begin tick(); n++; end
    chk("to_latency", n, 10);
    chk("to_err", tx_data, 8'hEE);
    chk("to_strobes", strobe_cnt - s0, 1);
    chk("to_tgt", {s_type, s_rw, s_addr}, {1'b0, 1'b0, 9'h010});
    instr_force = 1'b0;
    txq.delete();
    collect(1, 1'b0);
    chk("to_err_taken", {txq.size() == 1, busy}, {1'b1, 1'b0});

    // invalid header
    s0 = strobe_cnt;
    send_byte(8'h42);
    chk("bad_hdr", {tx_valid, tx_data}, {1'b1, 8'hEE});
    tick();
    chk("bad_idle", busy, 0);
    chk("bad_nostrobe", strobe_cnt - s0, 0);

    // inter-byte timeout mid-write
    s0 = strobe_cnt; a0 = tx_acc_cnt;
    send_byte(8'hA0); send_byte(8'h01);
    repeat (19) tick();
    chk("rxto_still_busy", busy, 1);
    tick();
    chk("rxto_idle", busy, 0);
    chk("rxto_nostrobe", strobe_cnt - s0, 0);
    chk("rxto_notx", tx_acc_cnt - a0, 0);
    chk("rxto_en", enable, 1);

    // halt, then run again
    send_byte(8'h00);
    txq.delete();
    collect(1, 1'b0);
    chk("halt_ack", qb(0), 8'hA5);
    chk("halt_en", enable, 0);
    send_byte(8'h40);
    txq.delete();
    collect(1, 1'b0);
    chk("rerun_en", enable, 1);

    // reset during the third response byte
    rsp_en = 1'b1;
    send_byte(8'hE1); send_byte(8'h03);
    txq.delete();
    collect(2, 1'b0);
    chk("pre_rst_byte3", {tx_valid, tx_data}, {1'b1, 8'hDE});
    tx_ready = 1'b0; rst_n = 1'b0;
    tick();
    chk("arst_txv", tx_valid, 0);
    chk("arst_en", enable, 0);
    chk("arst_busy", busy, 0);
    chk("arst_txd", tx_data, 0);
    rst_n = 1'b1; rsp_en = 1'b0;
    tick();
    send_byte(8'h40);
    txq.delete();
    collect(1, 1'b0);
    chk("post_rst_ack", qb(0), 8'hA5);
    chk("post_rst_en", enable, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
